// File: rtl/axis_gather_if.sv
// Bus bundle for axis_gather: N packed input streams plus the single gathered output stream.
// "slave" is the gather block's view, "master" is the view of whatever surrounds it.
interface axis_gather_if #(
   parameter int NUM_GATHER = 6,
   parameter int DATA_WIDTH = 256
);
   logic [NUM_GATHER-1:0]            s_axis_tvalid;
   logic [NUM_GATHER-1:0]            s_axis_tready;
   logic [NUM_GATHER*DATA_WIDTH-1:0] s_axis_tdata;
   logic [NUM_GATHER-1:0]            s_axis_tlast;
   logic                             m_axis_tvalid;
   logic                             m_axis_tready;
   logic [NUM_GATHER*DATA_WIDTH-1:0] m_axis_tdata;
   logic                             m_axis_tlast;

   modport slave (
      input  s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_tready,
      output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast
   );

   modport master (
      output s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_tready,
      input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast
   );
endinterface

// File: rtl/axis_gather.sv
// Gathers one beat from each of NUM_GATHER AXI-Stream inputs into a single wide output beat.
// Each stream has its own holding slot, so skewed inputs stall individually until the set is complete.
module axis_gather #(
   parameter int NUM_GATHER = 6,
   parameter int DATA_WIDTH = 256
) (
   input  logic          clk,
   input  logic          rst_n,
   axis_gather_if.slave  bus,
   output logic          err_misalign
);

   logic [NUM_GATHER-1:0]            hold_valid_reg;
   logic [NUM_GATHER-1:0]            hold_last_reg;
   logic [DATA_WIDTH-1:0]            hold_data_reg [NUM_GATHER];
   logic [NUM_GATHER*DATA_WIDTH-1:0] gather_data;

   logic                             m_valid_reg;
   logic [NUM_GATHER*DATA_WIDTH-1:0] m_data_reg;
   logic                             m_last_reg;
   logic                             err_reg;

   logic                             load;
   logic [NUM_GATHER-1:0]            ready;
   logic [NUM_GATHER-1:0]            accept;
   logic                             last_mismatch;

   // A slot may take new data when empty, or when its current contents leave this cycle.
   assign load          = (&hold_valid_reg) & (~m_valid_reg | bus.m_axis_tready);
   assign ready         = ~hold_valid_reg | {NUM_GATHER{load}};
   assign accept        = bus.s_axis_tvalid & ready;
   assign last_mismatch = ~((&hold_last_reg) | ~(|hold_last_reg));

   genvar gi;
   generate
      for (gi = 0; gi < NUM_GATHER; gi++) begin : g_pack
         assign gather_data[gi*DATA_WIDTH +: DATA_WIDTH] = hold_data_reg[gi];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_valid_reg <= '0;
         hold_last_reg  <= '0;
         for (int n = 0; n < NUM_GATHER; n++) begin
            hold_data_reg[n] <= '0;
         end
      end else begin
         for (int n = 0; n < NUM_GATHER; n++) begin
            if (accept[n]) begin
               hold_valid_reg[n] <= 1'b1;
               hold_data_reg[n]  <= bus.s_axis_tdata[n*DATA_WIDTH +: DATA_WIDTH];
               hold_last_reg[n]  <= bus.s_axis_tlast[n];
            end else if (load) begin
               hold_valid_reg[n] <= 1'b0;
            end
         end
      end
   end

   // Output register: only a load or a downstream handshake may change it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid_reg <= 1'b0;
         m_data_reg  <= '0;
         m_last_reg  <= 1'b0;
         err_reg     <= 1'b0;
      end else if (load) begin
         m_valid_reg <= 1'b1;
         m_data_reg  <= gather_data;
         m_last_reg  <= hold_last_reg[0];
         err_reg     <= err_reg | last_mismatch;
      end else if (m_valid_reg && bus.m_axis_tready) begin
         m_valid_reg <= 1'b0;
      end
   end

   assign bus.s_axis_tready = ready;
   assign bus.m_axis_tvalid = m_valid_reg;
   assign bus.m_axis_tdata  = m_data_reg;
   assign bus.m_axis_tlast  = m_last_reg;
   assign err_misalign      = err_reg;

endmodule

// File: tb/tb_axis_gather.sv
// Directed bench for axis_gather with two 8-bit streams: reset, skew, backpressure,
// streaming, tlast misalignment and mid-operation reset.
module tb_axis_gather;

   logic clk;
   logic rst_n;
   logic err;
   int   total;
   int   bad;

   axis_gather_if #(.NUM_GATHER(2), .DATA_WIDTH(8)) bus ();

   axis_gather #(.NUM_GATHER(2), .DATA_WIDTH(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (bus),
      .err_misalign (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   always @(negedge clk) begin
      if (rst_n && bus.m_axis_tvalid && bus.m_axis_tready)
         $display("beat data=%h last=%b err=%b", bus.m_axis_tdata, bus.m_axis_tlast, err);
   end

   task automatic chk(input string tag, input logic ok, input logic [15:0] obs,
                      input logic [15:0] exp);
      total++;
      if (ok !== 1'b1) begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] v, input logic [7:0] d1, input logic [7:0] d0,
                        input logic [1:0] l);
      bus.s_axis_tvalid = v;
      bus.s_axis_tdata  = {d1, d0};
      bus.s_axis_tlast  = l;
   endtask

   initial begin
      logic [7:0]  b;
      logic [15:0] exp_data;
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      bus.m_axis_tready = 1'b0;
      drive(2'b00, 8'h00, 8'h00, 2'b00);

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_mvalid", bus.m_axis_tvalid === 1'b0, bus.m_axis_tvalid, 1'b0);
      chk("rst_mdata",  bus.m_axis_tdata === 16'h0000, bus.m_axis_tdata, 16'h0000);
      chk("rst_mlast",  bus.m_axis_tlast === 1'b0, bus.m_axis_tlast, 1'b0);
      chk("rst_err",    err === 1'b0, err, 1'b0);
      rst_n = 1'b1;
      #1;
      chk("rst_ready",  bus.s_axis_tready === 2'b11, bus.s_axis_tready, 2'b11);

      // Skew: stream0 at cycle 0, stream1 at cycle 3
      bus.m_axis_tready = 1'b1;
      nxt(); drive(2'b01, 8'h00, 8'h11, 2'b00); #1;
      chk("skew_c0_ready", bus.s_axis_tready === 2'b11, bus.s_axis_tready, 2'b11);
      nxt(); drive(2'b00, 8'h00, 8'h00, 2'b00); #1;
      chk("skew_c1_ready", bus.s_axis_tready === 2'b10, bus.s_axis_tready, 2'b10);
      nxt(); #1;
      chk("skew_c2_ready", bus.s_axis_tready === 2'b10, bus.s_axis_tready, 2'b10);
      nxt(); drive(2'b10, 8'h22, 8'h00, 2'b00); #1;
      chk("skew_c3_ready", bus.s_axis_tready === 2'b10, bus.s_axis_tready, 2'b10);
      nxt(); drive(2'b00, 8'h00, 8'h00, 2'b00); #1;
      chk("skew_c4_mvalid", bus.m_axis_tvalid === 1'b0, bus.m_axis_tvalid, 1'b0);
      chk("skew_c4_ready",  bus.s_axis_tready === 2'b11, bus.s_axis_tready, 2'b11);
      nxt(); #1;
      chk("skew_c5_mvalid", bus.m_axis_tvalid === 1'b1, bus.m_axis_tvalid, 1'b1);
      chk("skew_c5_mdata",  bus.m_axis_tdata === 16'h2211, bus.m_axis_tdata, 16'h2211);
      chk("skew_c5_mlast",  bus.m_axis_tlast === 1'b0, bus.m_axis_tlast, 1'b0);
      nxt(); #1;
      chk("skew_c6_mvalid", bus.m_axis_tvalid === 1'b0, bus.m_axis_tvalid, 1'b0);

      // Backpressure: four sets offered while downstream stalls
      bus.m_axis_tready = 1'b0;
      nxt(); drive(2'b11, 8'h31, 8'h30, 2'b00); #1;
      chk("bp_c0_ready", bus.s_axis_tready === 2'b11, bus.s_axis_tready, 2'b11);
      nxt(); drive(2'b11, 8'h41, 8'h40, 2'b00); #1;
      chk("bp_c1_ready", bus.s_axis_tready === 2'b11, bus.s_axis_tready, 2'b11);
      nxt(); drive(2'b11, 8'h51, 8'h50, 2'b00); #1;
      chk("bp_c2_ready",  bus.s_axis_tready === 2'b00, bus.s_axis_tready, 2'b00);
      chk("bp_c2_mvalid", bus.m_axis_tvalid === 1'b1, bus.m_axis_tvalid, 1'b1);
      chk("bp_c2_mdata",  bus.m_axis_tdata === 16'h3130, bus.m_axis_tdata, 16'h3130);
      nxt(); #1;
      chk("bp_c3_ready", bus.s_axis_tready === 2'b00, bus.s_axis_tready, 2'b00);
      chk("bp_c3_mdata", bus.m_axis_tdata === 16'h3130, bus.m_axis_tdata, 16'h3130);
      nxt(); #1;
      chk("bp_c4_ready",  bus.s_axis_tready === 2'b00, bus.s_axis_tready, 2'b00);
      chk("bp_c4_mvalid", bus.m_axis_tvalid === 1'b1, bus.m_axis_tvalid, 1'b1);
      chk("bp_c4_mdata",  bus.m_axis_tdata === 16'h3130, bus.m_axis_tdata, 16'h3130);
      // Release with both slots full and both inputs valid: load and refill together
      nxt(); bus.m_axis_tready = 1'b1; #1;
      chk("simul_ready", bus.s_axis_tready === 2'b11, bus.s_axis_tready, 2'b11);
      chk("simul_mdata", bus.m_axis_tdata === 16'h3130, bus.m_axis_tdata, 16'h3130);
      nxt(); drive(2'b11, 8'h61, 8'h60, 2'b00); #1;
      chk("bp_c6_mvalid", bus.m_axis_tvalid === 1'b1, bus.m_axis_tvalid, 1'b1);
      chk("bp_c6_mdata",  bus.m_axis_tdata === 16'h4140, bus.m_axis_tdata, 16'h4140);
      nxt(); drive(2'b00, 8'h00, 8'h00, 2'b00); #1;
      chk("bp_c7_mvalid", bus.m_axis_tvalid === 1'b1, bus.m_axis_tvalid, 1'b1);
      chk("bp_c7_mdata",  bus.m_axis_tdata === 16'h5150, bus.m_axis_tdata, 16'h5150);
      nxt(); #1;
      chk("bp_c8_mvalid", bus.m_axis_tvalid === 1'b1, bus.m_axis_tvalid, 1'b1);
      chk("bp_c8_mdata",  bus.m_axis_tdata === 16'h6160, bus.m_axis_tdata, 16'h6160);
      nxt(); #1;
      chk("bp_c9_mvalid", bus.m_axis_tvalid === 1'b0, bus.m_axis_tvalid, 1'b0);

      // Streaming 0x00..0x0F back to back
      for (int i = 0; i < 18; i++) begin
         nxt();
         if (i < 16) drive(2'b11, 8'(i), 8'(i), 2'b00);
         else        drive(2'b00, 8'h00, 8'h00, 2'b00);
         #1;
         chk("stream_ready", bus.s_axis_tready === 2'b11, bus.s_axis_tready, 2'b11);
         if (i >= 2) begin
            b = 8'(i - 2);
            exp_data = {b, b};
            chk("stream_mvalid", bus.m_axis_tvalid === 1'b1, bus.m_axis_tvalid, 1'b1);
            chk("stream_mdata",  bus.m_axis_tdata === exp_data, bus.m_axis_tdata, exp_data);
         end
      end
      nxt(); #1;
      chk("stream_end_mvalid", bus.m_axis_tvalid === 1'b0, bus.m_axis_tvalid, 1'b0);

      // Misalignment: stream0 last=1, stream1 last=0
      nxt(); drive(2'b11, 8'h77, 8'h66, 2'b01);
      nxt(); drive(2'b00, 8'h00, 8'h00, 2'b00); #1;
      chk("mis_pre_err", err === 1'b0, err, 1'b0);
      nxt(); #1;
      chk("mis_err",   err === 1'b1, err, 1'b1);
      chk("mis_mlast", bus.m_axis_tlast === 1'b1, bus.m_axis_tlast, 1'b1);
      chk("mis_mdata", bus.m_axis_tdata === 16'h7766, bus.m_axis_tdata, 16'h7766);
      nxt(); drive(2'b11, 8'h89, 8'h88, 2'b00);
      nxt(); drive(2'b00, 8'h00, 8'h00, 2'b00);
      nxt(); #1;
      chk("mis_sticky_err", err === 1'b1, err, 1'b1);
      chk("mis_next_mlast", bus.m_axis_tlast === 1'b0, bus.m_axis_tlast, 1'b0);
      chk("mis_next_mdata", bus.m_axis_tdata === 16'h8988, bus.m_axis_tdata, 16'h8988);

      // Reset mid-operation: output valid and slot0 refilled
      nxt(); bus.m_axis_tready = 1'b0; drive(2'b11, 8'h99, 8'h98, 2'b00);
      nxt(); drive(2'b01, 8'h00, 8'hAA, 2'b00);
      nxt(); drive(2'b00, 8'h00, 8'h00, 2'b00); #1;
      chk("mr_pre_mvalid", bus.m_axis_tvalid === 1'b1, bus.m_axis_tvalid, 1'b1);
      chk("mr_pre_mdata",  bus.m_axis_tdata === 16'h9998, bus.m_axis_tdata, 16'h9998);
      chk("mr_pre_ready",  bus.s_axis_tready === 2'b10, bus.s_axis_tready, 2'b10);
      #1 rst_n = 1'b0;
      #1;
      chk("mr_mvalid", bus.m_axis_tvalid === 1'b0, bus.m_axis_tvalid, 1'b0);
      chk("mr_mdata",  bus.m_axis_tdata === 16'h0000, bus.m_axis_tdata, 16'h0000);
      chk("mr_mlast",  bus.m_axis_tlast === 1'b0, bus.m_axis_tlast, 1'b0);
      chk("mr_err",    err === 1'b0, err, 1'b0);
      chk("mr_ready",  bus.s_axis_tready === 2'b11, bus.s_axis_tready, 2'b11);
      nxt();
      nxt(); rst_n = 1'b1; bus.m_axis_tready = 1'b1;
      drive(2'b11, 8'hBC, 8'hBB, 2'b00); #1;
      chk("mr_post_ready", bus.s_axis_tready === 2'b11, bus.s_axis_tready, 2'b11);
      nxt(); drive(2'b00, 8'h00, 8'h00, 2'b00);
      nxt(); #1;
      chk("mr_post_mvalid", bus.m_axis_tvalid === 1'b1, bus.m_axis_tvalid, 1'b1);
      chk("mr_post_mdata",  bus.m_axis_tdata === 16'hBCBB, bus.m_axis_tdata, 16'hBCBB);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
